// File: rtl/trig_capture_if.sv
// Read-out stream of trig_capture: valid/ready handshake carrying converted samples.
interface trig_capture_if;
  logic [13:0] rd_data;
  logic        rd_valid;
  logic        rd_ready;
  logic        rd_last;

  modport master (output rd_data, rd_valid, rd_last, input rd_ready);
  modport slave  (input rd_data, rd_valid, rd_last, output rd_ready);
endinterface

// File: rtl/trig_capture.sv
// Triggered capture buffer: circular pre/post-trigger sample store with streamed read-out.
// Optional trigger timestamp counter is enabled by defining CAPTURE_TIMESTAMP_EN.
module trig_capture #(
  parameter int DEPTH   = 1024,
  parameter int PRETRIG = 256
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [13:0]    ain,
  input  logic           trg,
  input  logic           arm,
  input  logic           abort,
  trig_capture_if.master rd,
  output logic           busy,
  output logic [31:0]    trig_time
);
  localparam int AW       = $clog2(DEPTH);
  localparam int CW       = AW + 1;
  localparam int POST_LEN = DEPTH - PRETRIG;

  typedef enum logic [2:0] {IDLE, FILL, ARMED, POST, READ} state_t;
  state_t state, state_next;

  logic [13:0]   mem [DEPTH];
  logic [13:0]   din, ram_q, rd_data;
  logic [AW-1:0] wptr, trig_addr, rd_addr, out_cnt;
  logic [CW-1:0] cnt;
  logic          we, start, latch_trig, issue, load_out, xfer;
  logic          ram_v, rd_valid, rd_last;

  assign din      = {~ain[13], ain[12:0]};
  assign xfer     = rd_valid && rd.rd_ready;
  assign load_out = ram_v && (!rd_valid || rd.rd_ready);
  // cnt doubles as the read-issue index in READ; the window starts PRETRIG before the trigger.
  assign rd_addr  = trig_addr - AW'(PRETRIG) + cnt[AW-1:0];
  assign busy     = (state != IDLE);

  assign rd.rd_data  = rd_data;
  assign rd.rd_valid = rd_valid;
  assign rd.rd_last  = rd_last;

  // NOTE: every output gets a default first so this block never infers a latch.
  always_comb begin
    state_next = state;
    we         = 1'b0;
    start      = 1'b0;
    latch_trig = 1'b0;
    issue      = 1'b0;
    unique case (state)
      IDLE: if (arm) begin
        state_next = FILL;
        start      = 1'b1;
      end
      FILL: begin
        we = 1'b1;
        if (cnt == CW'(PRETRIG - 1)) state_next = ARMED;
      end
      ARMED: begin
        we = 1'b1;
        if (trg) begin
          latch_trig = 1'b1;
          state_next = (POST_LEN == 1) ? READ : POST;
        end
      end
      POST: begin
        we = 1'b1;
        if (cnt == CW'(POST_LEN - 1)) state_next = READ;
      end
      READ: begin
        issue = (cnt != CW'(DEPTH)) && (!ram_v || load_out);
        if (xfer && rd_last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (abort) begin
      state_next = IDLE;
      we         = 1'b0;
      start      = 1'b0;
      latch_trig = 1'b0;
      issue      = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr      <= '0;
      cnt       <= '0;
      trig_addr <= '0;
      out_cnt   <= '0;
      ram_v     <= 1'b0;
      rd_valid  <= 1'b0;
      rd_last   <= 1'b0;
      rd_data   <= '0;
    end else begin
      if (start)   wptr <= '0;
      else if (we) wptr <= wptr + 1'b1;

      // Trigger cycle already wrote post-trigger sample 0, so POST starts counting at 1.
      if (state_next != state)
        cnt <= (state_next == POST) ? CW'(1) : '0;
      else if (state == FILL || state == POST || issue)
        cnt <= cnt + 1'b1;

      if (latch_trig) trig_addr <= wptr;

      if (state != READ || abort) begin
        ram_v    <= 1'b0;
        rd_valid <= 1'b0;
        rd_last  <= 1'b0;
        out_cnt  <= '0;
      end else begin
        if (issue)         ram_v <= 1'b1;
        else if (load_out) ram_v <= 1'b0;
        if (load_out) begin
          rd_valid <= 1'b1;
          rd_data  <= ram_q;
          rd_last  <= (out_cnt == AW'(DEPTH - 1));
          out_cnt  <= out_cnt + 1'b1;
        end else if (xfer) begin
          rd_valid <= 1'b0;
          rd_last  <= 1'b0;
        end
      end
    end
  end

  // NOTE: the sample buffer and its read register carry no reset so they map onto block RAM.
  always_ff @(posedge clk) begin
    if (we)    mem[wptr] <= din;
    if (issue) ram_q     <= mem[rd_addr];
  end

`ifdef CAPTURE_TIMESTAMP_EN
  logic [31:0] ts;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts        <= '0;
      trig_time <= '0;
    end else begin
      ts <= ts + 1'b1;
      if (latch_trig) trig_time <= ts;
    end
  end
`else
  assign trig_time = '0;
`endif

endmodule
